// File: rtl/sdr_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : sdr_wr_sched
// Purpose  : Write-request scheduler in front of the SDRAM single-write
//            sequencer. Linear user addresses are queued in a small FIFO and
//            split into bank/row/column. One request is issued per address.
//            The next request waits until the sequencer reports wr_exit.
//            A watchdog flags a sequencer that never finishes.
// Ports    : clk, rst (sync, active-high)
//            usr_wr_vld / usr_wr_addr[23:0] / usr_wr_rdy - user push side
//            sdr_wr_req, sdr_bank_addr[1:0], sdr_row_addr[12:0],
//            sdr_col_addr[8:0]                          - sequencer request
//            wr_exit                                    - sequencer done pulse
//            busy, fifo_cnt, err_timeout                - status
// Revision : 1.0 - initial release
// ============================================================================
module sdr_wr_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     usr_wr_vld,
    input  logic [23:0]              usr_wr_addr,
    output logic                     usr_wr_rdy,
    output logic                     sdr_wr_req,
    output logic [1:0]               sdr_bank_addr,
    output logic [12:0]              sdr_row_addr,
    output logic [8:0]               sdr_col_addr,
    input  logic                     wr_exit,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     err_timeout
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_WD_W  = $clog2(TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_MAX = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [23:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_WD_W-1:0]    r_wd;
    logic                 r_req;
    logic [1:0]           r_bank;
    logic [12:0]          r_row;
    logic [8:0]           r_col;
    logic                 r_err;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tmo_hit;
    logic [23:0]          w_head;

    // Full check uses the registered count only: a same-cycle pop does not
    // make room for a push.
    assign usr_wr_rdy = (r_cnt < c_FULL);
    assign w_push     = usr_wr_vld & usr_wr_rdy;
    assign w_head     = r_mem[r_rd_ptr];

    // Next-state logic. wr_exit is tested before the watchdog so a done
    // pulse on the timeout cycle is never reported as a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_exit) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wd == c_WD_MAX) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage carries no reset; only the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= usr_wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    // Request, address split, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_bank <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_wd   <= '0;
            r_err  <= 1'b0;
        end else begin
            r_req <= w_pop;
            if (w_pop) begin
                r_bank <= w_head[23:22];
                r_row  <= w_head[21:9];
                r_col  <= w_head[8:0];
                r_wd   <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + c_WD_W'(1);
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sdr_wr_req    = r_req;
    assign sdr_bank_addr = r_bank;
    assign sdr_row_addr  = r_row;
    assign sdr_col_addr  = r_col;
    assign fifo_cnt      = r_cnt;
    assign err_timeout   = r_err;
    assign busy          = (r_state != S_IDLE) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sdr_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdr_wr_sched
// Purpose  : Self-checking bench for sdr_wr_sched (DEPTH=4, TIMEOUT=16).
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdr_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        usr_wr_vld;
    logic [23:0] usr_wr_addr;
    logic        usr_wr_rdy;
    logic        sdr_wr_req;
    logic [1:0]  sdr_bank_addr;
    logic [12:0] sdr_row_addr;
    logic [8:0]  sdr_col_addr;
    logic        wr_exit;
    logic        busy;
    logic [2:0]  fifo_cnt;
    logic        err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdr_wr_sched #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .usr_wr_vld    (usr_wr_vld),
        .usr_wr_addr   (usr_wr_addr),
        .usr_wr_rdy    (usr_wr_rdy),
        .sdr_wr_req    (sdr_wr_req),
        .sdr_bank_addr (sdr_bank_addr),
        .sdr_row_addr  (sdr_row_addr),
        .sdr_col_addr  (sdr_col_addr),
        .wr_exit       (wr_exit),
        .busy          (busy),
        .fifo_cnt      (fifo_cnt),
        .err_timeout   (err_timeout)
    );

    typedef struct {
        logic        vld;
        logic [23:0] addr;
        logic        ex;
        logic        req;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
        logic [2:0]  cnt;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic vld, logic [23:0] addr, logic ex,
                                logic req, logic [1:0] bank, logic [12:0] row,
                                logic [8:0] col, logic [2:0] cnt, logic bsy);
        vec_t v;
        v.vld = vld; v.addr = addr; v.ex = ex; v.req = req; v.bank = bank;
        v.row = row; v.col = col; v.cnt = cnt; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req"},  32'(sdr_wr_req), 0);
        chk({nm, "_bank"}, 32'(sdr_bank_addr), 0);
        chk({nm, "_row"},  32'(sdr_row_addr), 0);
        chk({nm, "_col"},  32'(sdr_col_addr), 0);
        chk({nm, "_err"},  32'(err_timeout), 0);
        chk({nm, "_cnt"},  32'(fifo_cnt), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_rdy"},  32'(usr_wr_rdy), 1);
    endtask

    task automatic pulse_exit();
        wr_exit = 1'b1;
        @(negedge clk);
        wr_exit = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        usr_wr_vld  = 1'b0;
        usr_wr_addr = '0;
        wr_exit     = 1'b0;

        // Single write, exit-in-idle and back-to-back drain.
        tbl.push_back(mk(1, 24'h9ABCDE, 0, 0, 2'd0, 13'h0000, 9'h000, 3'd1, 1));
        tbl.push_back(mk(0, 24'h000000, 0, 1, 2'd2, 13'h0D5E, 9'h0DE, 3'd0, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 24'h000000, 0, 0, 2'd2, 13'h0D5E, 9'h0DE, 3'd0, 1));
        tbl.push_back(mk(0, 24'h000000, 1, 0, 2'd2, 13'h0D5E, 9'h0DE, 3'd0, 0));
        tbl.push_back(mk(0, 24'h000000, 1, 0, 2'd2, 13'h0D5E, 9'h0DE, 3'd0, 0));
        tbl.push_back(mk(1, 24'h000000, 0, 0, 2'd2, 13'h0D5E, 9'h0DE, 3'd1, 1));
        tbl.push_back(mk(1, 24'h400201, 0, 1, 2'd0, 13'h0000, 9'h000, 3'd1, 1));
        tbl.push_back(mk(1, 24'hFFFFFF, 1, 0, 2'd0, 13'h0000, 9'h000, 3'd2, 1));
        tbl.push_back(mk(0, 24'h000000, 0, 1, 2'd1, 13'h0001, 9'h001, 3'd1, 1));
        tbl.push_back(mk(0, 24'h000000, 1, 0, 2'd1, 13'h0001, 9'h001, 3'd1, 1));
        tbl.push_back(mk(0, 24'h000000, 0, 1, 2'd3, 13'h1FFF, 9'h1FF, 3'd0, 1));
        tbl.push_back(mk(0, 24'h000000, 1, 0, 2'd3, 13'h1FFF, 9'h1FF, 3'd0, 0));

        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            usr_wr_vld  = tbl[i].vld;
            usr_wr_addr = tbl[i].addr;
            wr_exit     = tbl[i].ex;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),  32'(sdr_wr_req),    32'(tbl[i].req));
            chk($sformatf("v%0d_bank", i), 32'(sdr_bank_addr), 32'(tbl[i].bank));
            chk($sformatf("v%0d_row", i),  32'(sdr_row_addr),  32'(tbl[i].row));
            chk($sformatf("v%0d_col", i),  32'(sdr_col_addr),  32'(tbl[i].col));
            chk($sformatf("v%0d_cnt", i),  32'(fifo_cnt),      32'(tbl[i].cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy),          32'(tbl[i].bsy));
            chk($sformatf("v%0d_rdy", i),  32'(usr_wr_rdy),    32'(tbl[i].cnt < 3'd4));
        end
        usr_wr_vld = 1'b0;
        wr_exit    = 1'b0;

        // FIFO full while the sequencer is busy.
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'hABCDEF;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        @(negedge clk);
        chk("t2_first_req", 32'(sdr_wr_req), 1);
        for (int i = 0; i < 5; i++) begin
            usr_wr_vld  = 1'b1;
            usr_wr_addr = {2'(i), 13'(i + 1), 9'(i + 2)};
            chk($sformatf("t2_rdy%0d", i), 32'(usr_wr_rdy), 32'(i < 4));
            @(negedge clk);
        end
        usr_wr_vld = 1'b0;
        chk("t2_cnt_full", 32'(fifo_cnt), 4);
        chk("t2_rdy_full", 32'(usr_wr_rdy), 0);
        pulse_exit();
        chk("t2_cnt_idle", 32'(fifo_cnt), 4);
        @(negedge clk);
        chk("t2_pop_req", 32'(sdr_wr_req), 1);
        chk("t2_pop_cnt", 32'(fifo_cnt), 3);
        chk("t2_pop_bank", 32'(sdr_bank_addr), 0);
        chk("t2_pop_row", 32'(sdr_row_addr), 1);
        chk("t2_pop_col", 32'(sdr_col_addr), 2);

        // Push and pop in the same cycle at occupancy 2.
        pulse_exit();
        @(negedge clk);
        chk("t5_pop2_cnt", 32'(fifo_cnt), 2);
        chk("t5_pop2_col", 32'(sdr_col_addr), 3);
        pulse_exit();
        chk("t5_idle_cnt", 32'(fifo_cnt), 2);
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'h123456;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        chk("t5_pp_cnt", 32'(fifo_cnt), 2);
        chk("t5_pp_req", 32'(sdr_wr_req), 1);
        chk("t5_pp_col", 32'(sdr_col_addr), 4);
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'h654321;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        chk("t6_pre_cnt", 32'(fifo_cnt), 3);
        chk("t6_pre_busy", 32'(busy), 1);

        // Reset in WAIT with three entries queued.
        pulse_rst();
        chk_reset_vals("t6_rst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t6_noreq%0d", i), 32'(sdr_wr_req), 0);
            chk($sformatf("t6_idle%0d", i),  32'(busy), 0);
        end

        // Push-to-request latency and single-cycle pulse.
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'h000203;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        chk("lat_k_req", 32'(sdr_wr_req), 0);
        chk("lat_k_cnt", 32'(fifo_cnt), 1);
        @(negedge clk);
        chk("lat_k1_req", 32'(sdr_wr_req), 1);
        chk("lat_k1_row", 32'(sdr_row_addr), 1);
        chk("lat_k1_col", 32'(sdr_col_addr), 3);
        @(negedge clk);
        chk("lat_k2_req", 32'(sdr_wr_req), 0);

        // Timeout with a second entry queued.
        pulse_rst();
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'hC00011;
        @(negedge clk);
        usr_wr_addr = 24'h000155;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        chk("t4_req", 32'(sdr_wr_req), 1);
        chk("t4_bank", 32'(sdr_bank_addr), 3);
        chk("t4_col", 32'(sdr_col_addr), 9'h011);
        repeat (15) @(negedge clk);
        chk("t4_err_early", 32'(err_timeout), 0);
        @(negedge clk);
        chk("t4_err_set", 32'(err_timeout), 1);
        @(negedge clk);
        chk("t4_next_req", 32'(sdr_wr_req), 1);
        chk("t4_next_col", 32'(sdr_col_addr), 9'h155);
        chk("t4_err_sticky", 32'(err_timeout), 1);

        // wr_exit on the exact timeout cycle.
        pulse_rst();
        chk("t5_err_clr", 32'(err_timeout), 0);
        usr_wr_vld  = 1'b1;
        usr_wr_addr = 24'h400000;
        @(negedge clk);
        usr_wr_vld = 1'b0;
        @(negedge clk);
        chk("t5_tx_req", 32'(sdr_wr_req), 1);
        chk("t5_tx_bank", 32'(sdr_bank_addr), 1);
        repeat (15) @(negedge clk);
        pulse_exit();
        chk("t5_tx_err", 32'(err_timeout), 0);
        chk("t5_tx_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("t5_tx_err_late", 32'(err_timeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
